munoc_burst_error_slave: RTL and testbench
==========================================

Name: munoc_burst_error_slave

Overview:
Parametrised AXI default/error slave for the MUNOC fabric. It terminates any request routed to an unmapped address region. Unlike the single-transaction responder, it accepts up to OUTSTANDING pending writes and reads each, drains full W bursts, and returns ARLEN+1 error-response R beats per read. It also keeps a sticky routing-error flag for requests whose master node ID mismatches EXPECTED_NODE_ID.

Parameters:
BW_ID, 4, AXI ID width on AW/B/AR/R.
BW_DATA, 32, R data width.
BW_LEN, 8, ARLEN width.
BW_NODE_ID, 4, master node ID width.
OUTSTANDING, 4, depth of each AW-ID and AR FIFO; power of two, >=2.
ERROR_RESP, 2'b11, value driven on BRESP/RRESP (DECERR).
EXPECTED_NODE_ID, -1, expected master node ID; a negative value disables the check.

Ports:
clk  in  1  clock
rstnn  in  1  asynchronous reset, active low
awid  in  BW_ID  write ID
awnode  in  BW_NODE_ID  master node ID of the write
awvalid  in  1  AW valid
awready  out  1  AW ready
wlast  in  1  last W beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  BW_ID  response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  BW_ID  read ID
arlen  in  BW_LEN  burst length minus 1
arnode  in  BW_NODE_ID  master node ID of the read
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  BW_ID  read ID
rdata  out  BW_DATA  read data, constant 0
rresp  out  2  read response
rlast  out  1  last R beat
rvalid  out  1  R valid
rready  in  1  R ready
routing_error  out  1  sticky node-ID mismatch flag

Behaviour:
- Reset (rstnn=0, asynchronous): both FIFOs empty, beat counter 0, B register empty, routing_error 0. Consequently awready=arready=1 and wready=bvalid=rvalid=rlast=0. Any transaction in flight is dropped silently.
- AW path: awready = !awfifo_full. On awvalid&awready, awid is pushed. When full, awready is 0 even if a pop occurs in the same cycle.
- W path: wready = !awfifo_empty && (!bvalid || bready). Beats are accepted and discarded.
- On the wvalid&wready&wlast beat, the AW FIFO head is popped into the B register: bvalid=1 and bid=head ID on the next cycle. bresp=ERROR_RESP, held until bready.
- If B pops and a new wlast loads B in the same cycle, the new ID replaces it with bvalid staying 1 and no bubble.
- AR path: arready = !arfifo_full. On handshake, {arid, arlen} is pushed. Same full rule as AW.
- R path: rvalid = !arfifo_empty; rid = head ID; rdata=0; rresp=ERROR_RESP.
- R beat counter: BW_LEN bits. rlast = (cnt == head arlen).
- On rvalid&rready: if rlast, pop the head and clear cnt to 0; otherwise cnt+1.
- arlen=0 gives a single beat with rlast=1. arlen=255 gives 256 beats; the counter never wraps before rlast.
- Latency: first R beat appears 1 cycle after the AR handshake if the FIFO was empty; B appears 1 cycle after the wlast handshake.
- Write responses are returned in AW acceptance order, and reads complete in AR order. The read and write paths are fully independent.
- routing_error: if EXPECTED_NODE_ID>=0, it sets on any AW handshake with awnode!=EXPECTED_NODE_ID, or any AR handshake with arnode!=EXPECTED_NODE_ID. It clears only on reset. If EXPECTED_NODE_ID<0, it is tied to 0.

Test Plan:
- AR id=3, arlen=3, rready=1 -> 4 R beats on consecutive cycles, rid=3, rresp=2'b11, rdata=0, rlast only on the 4th beat.
- AW id=5 then 3 W beats with wlast on the 3rd, bready=1 -> bvalid 1 cycle after wlast, bid=5, bresp=2'b11, exactly one B.
- 5 AWs (ids 1..5) with no W traffic, OUTSTANDING=4 -> awready drops after the 4th; after one burst completes, id 5 is accepted; B IDs come out 1,2,3,4,5 in order.
- bready held 0 with a second burst ready -> wready=0 on that burst; release bready -> back-to-back B for both IDs with no bubble.
- EXPECTED_NODE_ID=2, AR with arnode=1 -> routing_error=1 the next cycle and stays 1 through later matching requests; pulse rstnn -> routing_error=0.
- rstnn asserted mid-way through an 8-beat read -> rvalid=0 immediately; after reset the FIFO is empty and arready=1.

Source files
------------

// File: rtl/munoc_burst_error_slave_if.sv
// AXI-style AW/W/B/AR/R handshake bundle between a fabric master and the MUNOC error slave.
// Pure wiring: no latency, no state.
// Backpressure travels on the usual valid/ready pairs.
interface munoc_burst_error_slave_if #(
    parameter int BW_ID      = 4,
    parameter int BW_DATA    = 32,
    parameter int BW_LEN     = 8,
    parameter int BW_NODE_ID = 4
);
    logic [BW_ID-1:0]      awid;
    logic [BW_NODE_ID-1:0] awnode;
    logic                  awvalid;
    logic                  awready;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [BW_ID-1:0]      bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [BW_ID-1:0]      arid;
    logic [BW_LEN-1:0]     arlen;
    logic [BW_NODE_ID-1:0] arnode;
    logic                  arvalid;
    logic                  arready;
    logic [BW_ID-1:0]      rid;
    logic [BW_DATA-1:0]    rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awnode, awvalid, wlast, wvalid, bready,
        output arid, arlen, arnode, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awnode, awvalid, wlast, wvalid, bready,
        input  arid, arlen, arnode, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/munoc_burst_error_slave.sv
// Small generic FIFO with registered pointers and a combinational head.
// Latency: an entry is visible at the head one cycle after push.
// Backpressure: caller must not push when full or pop when empty.
module munoc_burst_error_slave_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// Default/error AXI slave: absorbs bursts to unmapped space, answers DECERR, flags node-ID mismatches.
// Latency: B one cycle after the wlast beat; first R beat one cycle after AR into an empty queue.
// Backpressure: AW/AR stall when their FIFO is full; W stalls while B is held by bready=0.
module munoc_burst_error_slave #(
    parameter int         BW_ID            = 4,
    parameter int         BW_DATA          = 32,
    parameter int         BW_LEN           = 8,
    parameter int         BW_NODE_ID       = 4,
    parameter int         OUTSTANDING      = 4,
    parameter logic [1:0] ERROR_RESP       = 2'b11,
    parameter int         EXPECTED_NODE_ID = -1
) (
    input  logic                          clk,
    input  logic                          rstnn,
    munoc_burst_error_slave_if.slave      bus,
    output logic                          routing_error
);
    localparam bit                    NODE_CHECK = (EXPECTED_NODE_ID >= 0);
    localparam logic [BW_NODE_ID-1:0] EXP_NODE   = BW_NODE_ID'(NODE_CHECK ? EXPECTED_NODE_ID : 0);

    logic              aw_full, aw_empty, aw_push, aw_pop;
    logic [BW_ID-1:0]  aw_head;
    logic              ar_full, ar_empty, ar_push, ar_pop;
    logic [BW_ID+BW_LEN-1:0] ar_head;
    logic [BW_ID-1:0]  ar_head_id;
    logic [BW_LEN-1:0] ar_head_len;
    logic [BW_LEN-1:0] cnt;
    logic              r_hs;

    // ---------------- write side ----------------
    assign bus.awready = !aw_full;
    assign aw_push     = bus.awvalid && !aw_full;
    assign bus.wready  = !aw_empty && (!bus.bvalid || bus.bready);
    assign aw_pop      = bus.wvalid && bus.wready && bus.wlast;
    assign bus.bresp   = ERROR_RESP;

    munoc_burst_error_slave_fifo #(.WIDTH(BW_ID), .DEPTH(OUTSTANDING)) u_aw_fifo (
        .clk      (clk),
        .rstnn    (rstnn),
        .push     (aw_push),
        .push_dat (bus.awid),
        .pop      (aw_pop),
        .full     (aw_full),
        .empty    (aw_empty),
        .head_dat (aw_head)
    );

    // A reload takes priority over the pop so back-to-back responses have no bubble.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            bus.bvalid <= 1'b0;
            bus.bid    <= '0;
        end else if (aw_pop) begin
            bus.bvalid <= 1'b1;
            bus.bid    <= aw_head;
        end else if (bus.bready) begin
            bus.bvalid <= 1'b0;
        end
    end

    // ---------------- read side ----------------
    assign bus.arready = !ar_full;
    assign ar_push     = bus.arvalid && !ar_full;
    assign {ar_head_id, ar_head_len} = ar_head;

    munoc_burst_error_slave_fifo #(.WIDTH(BW_ID+BW_LEN), .DEPTH(OUTSTANDING)) u_ar_fifo (
        .clk      (clk),
        .rstnn    (rstnn),
        .push     (ar_push),
        .push_dat ({bus.arid, bus.arlen}),
        .pop      (ar_pop),
        .full     (ar_full),
        .empty    (ar_empty),
        .head_dat (ar_head)
    );

    assign bus.rvalid = !ar_empty;
    assign bus.rid    = ar_head_id;
    assign bus.rdata  = '0;
    assign bus.rresp  = ERROR_RESP;
    assign bus.rlast  = !ar_empty && (cnt == ar_head_len);
    assign r_hs       = bus.rvalid && bus.rready;
    assign ar_pop     = r_hs && bus.rlast;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            cnt <= '0;
        end else if (r_hs) begin
            cnt <= bus.rlast ? '0 : cnt + BW_LEN'(1);
        end
    end

    // ---------------- routing check ----------------
    generate
        if (NODE_CHECK) begin : g_node_check
            always_ff @(posedge clk or negedge rstnn) begin
                if (!rstnn) begin
                    routing_error <= 1'b0;
                end else if ((aw_push && (bus.awnode != EXP_NODE)) ||
                             (ar_push && (bus.arnode != EXP_NODE))) begin
                    routing_error <= 1'b1;
                end
            end
        end else begin : g_no_node_check
            assign routing_error = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_munoc_burst_error_slave.sv
// Directed bench for munoc_burst_error_slave with R/B scoreboards checked on the falling edge.
module tb_munoc_burst_error_slave;
    localparam int BW_ID      = 4;
    localparam int BW_DATA    = 32;
    localparam int BW_LEN     = 8;
    localparam int BW_NODE_ID = 4;

    logic clk   = 1'b0;
    logic rstnn = 1'b0;
    logic routing_error;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [3:0] id;
        logic       last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [3:0] bq[$];

    munoc_burst_error_slave_if #(
        .BW_ID(BW_ID), .BW_DATA(BW_DATA), .BW_LEN(BW_LEN), .BW_NODE_ID(BW_NODE_ID)
    ) bus ();

    munoc_burst_error_slave #(
        .BW_ID(BW_ID), .BW_DATA(BW_DATA), .BW_LEN(BW_LEN), .BW_NODE_ID(BW_NODE_ID),
        .OUTSTANDING(4), .ERROR_RESP(2'b11), .EXPECTED_NODE_ID(2)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .bus           (bus),
        .routing_error (routing_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every accepted R/B beat must match the head of its queue.
    always @(negedge clk) begin
        if (rstnn && bus.rvalid && bus.rready) begin
            tests++;
            assert (rq.size() != 0) else begin
                fails++;
                $error("FAIL r_extra: observed beat id %0h expected none", bus.rid);
            end
            if (rq.size() != 0) begin
                rbeat_t e;
                e = rq.pop_front();
                chk("r_id", bus.rid, e.id);
                chk("r_last", bus.rlast, e.last);
                chk("r_resp", bus.rresp, 2'b11);
                chk("r_data", bus.rdata, 0);
            end
        end
        if (rstnn && bus.bvalid && bus.bready) begin
            tests++;
            assert (bq.size() != 0) else begin
                fails++;
                $error("FAIL b_extra: observed id %0h expected none", bus.bid);
            end
            if (bq.size() != 0) begin
                logic [3:0] eb;
                eb = bq.pop_front();
                chk("b_id", bus.bid, eb);
                chk("b_resp", bus.bresp, 2'b11);
            end
        end
    end

    task automatic do_ar(input logic [3:0] id, input logic [7:0] len, input logic [3:0] node);
        int n = 0;
        bus.arvalid = 1'b1; bus.arid = id; bus.arlen = len; bus.arnode = node;
        while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ar_wait", n < 50, 1);
        for (int i = 0; i <= int'(len); i++) rq.push_back('{id, (i == int'(len))});
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [3:0] node);
        int n = 0;
        bus.awvalid = 1'b1; bus.awid = id; bus.awnode = node;
        while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
        chk("aw_wait", n < 50, 1);
        bq.push_back(id);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input int beats);
        for (int b = 0; b < beats; b++) begin
            int n = 0;
            bus.wvalid = 1'b1; bus.wlast = (b == beats - 1);
            while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
            chk("w_wait", n < 50, 1);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
        chk("drain", n < 2000, 1);
    endtask

    initial begin
        int n;
        bus.awid = '0; bus.awnode = '0; bus.awvalid = 1'b0;
        bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.arid = '0; bus.arlen = '0; bus.arnode = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        // Reset state
        #1;
        chk("rst_awready", bus.awready, 1);
        chk("rst_arready", bus.arready, 1);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_routing", routing_error, 0);
        @(posedge clk); @(posedge clk); #1;
        rstnn = 1'b1;

        // 4-beat read on consecutive cycles
        do_ar(4'd3, 8'd3, 4'd2);
        chk("r_first_latency", bus.rvalid, 1);
        n = 0;
        while (rq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("r_burst_cycles", n, 4);
        chk("r_idle_after", bus.rvalid, 0);

        // Single write burst of 3 beats
        do_aw(4'd5, 4'd2);
        do_w(3);
        chk("b_latency_vld", bus.bvalid, 1);
        chk("b_latency_id", bus.bid, 5);
        chk("b_latency_resp", bus.bresp, 2'b11);
        @(posedge clk); #1;
        chk("b_single", bus.bvalid, 0);

        // Fill the AW queue, fifth request waits for a slot
        for (int i = 1; i <= 4; i++) do_aw(4'(i), 4'd2);
        bus.awvalid = 1'b1; bus.awid = 4'd5; bus.awnode = 4'd2;
        chk("aw_full_a", bus.awready, 0);
        @(posedge clk); #1;
        chk("aw_full_b", bus.awready, 0);
        do_w(1);
        chk("aw_slot_free", bus.awready, 1);
        bq.push_back(4'd5);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) do_w(1);
        drain();

        // B held by bready=0 blocks the next wlast; release gives back-to-back B
        bus.bready = 1'b0;
        do_aw(4'd7, 4'd2);
        do_aw(4'd8, 4'd2);
        do_w(1);
        chk("bhold_vld", bus.bvalid, 1);
        chk("bhold_id", bus.bid, 7);
        bus.wvalid = 1'b1; bus.wlast = 1'b1;
        @(posedge clk); #1;
        chk("bhold_wready", bus.wready, 0);
        chk("bhold_id2", bus.bid, 7);
        bus.bready = 1'b1;
        #1;
        chk("brel_wready", bus.wready, 1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("b2b_vld", bus.bvalid, 1);
        chk("b2b_id", bus.bid, 8);
        @(posedge clk); #1;
        chk("b2b_done", bus.bvalid, 0);
        drain();

        // 256-beat read with random rready stalls
        do_ar(4'd6, 8'd255, 4'd2);
        n = 0;
        while (rq.size() != 0 && n < 3000) begin
            bus.rready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        bus.rready = 1'b1;
        chk("r256_done", n < 3000, 1);
        chk("r256_idle", bus.rvalid, 0);
        chk("routing_clean", routing_error, 0);

        // Node-ID mismatch is sticky until reset
        do_ar(4'd2, 8'd0, 4'd1);
        chk("routing_set", routing_error, 1);
        do_ar(4'd3, 8'd1, 4'd2);
        chk("routing_sticky_ar", routing_error, 1);
        do_aw(4'd9, 4'd2);
        do_w(1);
        drain();
        chk("routing_sticky_aw", routing_error, 1);
        rstnn = 1'b0;
        #1;
        chk("routing_rst", routing_error, 0);
        @(posedge clk); #1;
        rstnn = 1'b1;

        // Reset in the middle of an 8-beat read
        do_ar(4'd4, 8'd7, 4'd2);
        n = 0;
        while (rq.size() > 5 && n < 50) begin @(posedge clk); #1; n++; end
        chk("mid_wait", n < 50, 1);
        #2;
        rstnn = 1'b0;
        #1;
        chk("mid_rvalid", bus.rvalid, 0);
        chk("mid_rlast", bus.rlast, 0);
        chk("mid_arready", bus.arready, 1);
        rq.delete();
        @(posedge clk); #1;
        rstnn = 1'b1;
        #1;
        chk("post_rvalid", bus.rvalid, 0);
        chk("post_arready", bus.arready, 1);
        do_ar(4'd1, 8'd1, 4'd2);
        drain();
        chk("post_routing", routing_error, 0);

        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
